clock_manager: RTL and testbench
================================

CLOCK_MANAGER -- requirements
Module: clock_manager

Interface
REQ-001 Parameter CHANNELS, default 2, number of clock-enable channels, legal 1..4.
REQ-002 Parameter DIV_WIDTH, default 8, width of each divider register and counter.
REQ-003 Parameter LOCK_DELAY, default 16, consecutive synchronised-lock cycles required before release, legal 1..65535.
REQ-004 Parameter DEFAULT_DIV, default 3, divider value loaded into every channel at reset.
REQ-005 Port clock_in  input  1  single system clock (PLL output domain); one clock, all logic on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port pll_locked  input  1  raw PLL lock flag, asynchronous to clock_in.
REQ-008 Port div_wr  input  1  divider write strobe, one cycle.
REQ-009 Port div_sel  input  2  channel index for div_wr.
REQ-010 Port div_data  input  DIV_WIDTH  new divider value.
REQ-011 Port rst_out  output  1  synchronous active-high reset for downstream logic.
REQ-012 Port ready  output  1  high while in RUN.
REQ-013 Port ce  output  CHANNELS  per-channel one-cycle clock-enable pulses.
REQ-014 Port sq  output  CHANNELS  per-channel square wave, toggles on each ce pulse.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchroniser; lock_s is the second flop output.
REQ-016 States SHALL be WAIT_LOCK, STABLE, RUN; reset state WAIT_LOCK.
REQ-017 WAIT_LOCK: stable counter held 0; lock_s=1 -> STABLE.
REQ-018 STABLE: counter increments each cycle lock_s=1; lock_s=0 -> WAIT_LOCK with counter cleared; counter reaching LOCK_DELAY-1 with lock_s=1 -> RUN.
REQ-019 RUN: lock_s=0 -> WAIT_LOCK next edge; no other exit except reset.
REQ-020 rst_out SHALL be 1 and ready 0 in every state except RUN; both registered from state (rst_out=0, ready=1 on the cycle state==RUN).
REQ-021 With pll_locked held high, ready SHALL rise exactly LOCK_DELAY+3 edges after the first edge sampling pll_locked=1.
REQ-022 Per channel: counter cnt[i] cleared on RUN entry and outside RUN; in RUN, cnt[i]==div[i] -> ce[i]=1 for that cycle and cnt[i] wraps to 0, else cnt[i]+1.
REQ-023 ce period SHALL be div[i]+1 cycles; div[i]=0 -> ce[i] high every RUN cycle; first pulse div[i]+1 cycles after RUN entry.
REQ-024 ce SHALL be 0 outside RUN; sq[i] toggles on each ce[i]=1 and is cleared on leaving RUN.
REQ-025 div_wr=1 SHALL load div[div_sel] with div_data and clear cnt[div_sel] on the same edge, in any state; ce[div_sel] is suppressed that cycle.
REQ-026 div_wr with div_sel>=CHANNELS SHALL be ignored.
REQ-027 Lock loss in RUN SHALL drop ready, assert rst_out, zero ce on the following edge; divider registers retained.

Reset
REQ-028 reset=1 SHALL force on the next edge: state WAIT_LOCK, synchroniser flops 0, stable counter 0, rst_out=1, ready=0, ce=0, sq=0, all cnt=0, all div=DEFAULT_DIV.
REQ-029 reset SHALL take priority over div_wr and lock events in the same cycle.

Configuration
REQ-030 Macro CLOCK_MANAGER_LOSS_COUNT_EN defined: add output loss_count (8 bits), incremented saturating at 255 on each RUN->WAIT_LOCK transition, cleared by reset.
REQ-031 Macro undefined: no loss_count port, no counter logic; all other behaviour identical.

Verification (CHANNELS=2, LOCK_DELAY=16, DEFAULT_DIV=3, DIV_WIDTH=8)
REQ-032 Reset released, pll_locked high from cycle 0 -> ready=1 and rst_out=0 at cycle 19; ce[0], ce[1] first pulse 4 cycles later, then every 4 cycles.
REQ-033 pll_locked glitches low for 3 cycles at STABLE count 10 -> return to WAIT_LOCK; ready rises 19 cycles after lock re-asserts.
REQ-034 In RUN, write div_sel=1 div_data=0 -> ce[1] low that cycle, high every cycle after; ce[0] unaffected period 4; sq[1] toggles every cycle.
REQ-035 In RUN, pll_locked falls -> 2 cycles later lock_s=0, next edge ready=0, rst_out=1, ce=0, sq=0; div values retained on relock.
REQ-036 Write div_sel=3 -> no change to any divider; reset asserted same cycle as div_wr to channel 0 -> div[0]=3.
REQ-037 With CLOCK_MANAGER_LOSS_COUNT_EN: 3 lock losses from RUN -> loss_count=3; reset -> 0.

Source files
------------

// File: rtl/clock_manager.sv
// Clock manager: PLL lock qualification, downstream reset release and per-channel clock-enable dividers.
// Optional loss counter enabled by defining CLOCK_MANAGER_LOSS_COUNT_EN.
module clock_manager #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_DELAY  = 16,
  parameter int DEFAULT_DIV = 3
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 div_wr,
  input  logic [1:0]           div_sel,
  input  logic [DIV_WIDTH-1:0] div_data,
  output logic                 rst_out,
  output logic                 ready,
  output logic [CHANNELS-1:0]  ce,
  output logic [CHANNELS-1:0]  sq
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
  ,
  output logic [7:0]           loss_count
`endif
);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_DELAY - 1);

  state_t               state;
  logic                 sync_p0;
  logic                 lock_s;
  logic [15:0]          stable_cnt;
  logic [DIV_WIDTH-1:0] div_r [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_r [CHANNELS];
  logic                 run_hold;

  // Dividers only advance while RUN is held; the entry edge and every exit edge clear them.
  assign run_hold = (state == RUN) && lock_s;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      lock_s     <= 1'b0;
      state      <= WAIT_LOCK;
      stable_cnt <= '0;
      ready      <= 1'b0;
      rst_out    <= 1'b1;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      loss_count <= '0;
`endif
    end else begin
      sync_p0 <= pll_locked;
      lock_s  <= sync_p0;
      case (state)
        WAIT_LOCK: begin
          stable_cnt <= '0;
          if (lock_s) state <= STABLE;
        end
        STABLE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
          end else if (stable_cnt == LOCK_LAST) begin
            state      <= RUN;
            stable_cnt <= '0;
            ready      <= 1'b1;
            rst_out    <= 1'b0;
          end else begin
            stable_cnt <= stable_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state   <= WAIT_LOCK;
            ready   <= 1'b0;
            rst_out <= 1'b1;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
            if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
`endif
          end
        end
        default: begin
          state      <= WAIT_LOCK;
          stable_cnt <= '0;
          ready      <= 1'b0;
          rst_out    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_r[i] <= DIV_WIDTH'(DEFAULT_DIV);
        cnt_r[i] <= '0;
      end
      ce <= '0;
      sq <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (div_wr && (div_sel == 2'(i))) begin
          div_r[i] <= div_data;
          cnt_r[i] <= '0;
          ce[i]    <= 1'b0;
          sq[i]    <= sq[i] & run_hold;
        end else if (run_hold) begin
          if (cnt_r[i] == div_r[i]) begin
            cnt_r[i] <= '0;
            ce[i]    <= 1'b1;
            sq[i]    <= ~sq[i];
          end else begin
            cnt_r[i] <= cnt_r[i] + 1'b1;
            ce[i]    <= 1'b0;
          end
        end else begin
          cnt_r[i] <= '0;
          ce[i]    <= 1'b0;
          sq[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_manager.sv
// Self-checking bench for clock_manager: per-cycle scoreboard plus scenario table and directed corner sequences.
module tb_clock_manager;

  localparam int CH = 2;
  localparam int LD = 16;
  localparam int DD = 3;
  localparam int DW = 8;

  logic          clock_in = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          div_wr = 1'b0;
  logic [1:0]    div_sel = 2'd0;
  logic [DW-1:0] div_data = '0;
  logic          rst_out;
  logic          ready;
  logic [CH-1:0] ce;
  logic [CH-1:0] sq;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
  logic [7:0]    loss_count;
`endif

  clock_manager #(.CHANNELS(CH), .DIV_WIDTH(DW), .LOCK_DELAY(LD), .DEFAULT_DIV(DD)) dut (
    .clock_in(clock_in), .reset(reset), .pll_locked(pll_locked), .div_wr(div_wr),
    .div_sel(div_sel), .div_data(div_data), .rst_out(rst_out), .ready(ready),
    .ce(ce), .sq(sq)
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
    , .loss_count(loss_count)
`endif
  );

  always #5 clock_in = ~clock_in;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference model state: expected outputs after the edge that samples the driven inputs
  typedef struct {
    logic [5:0] outs;
    int         loss;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int m_s1, m_s2, m_state, m_scnt, m_ready, m_loss;
  int m_cc[CH];
  int m_div[CH];
  int m_ce[CH];
  int m_sq[CH];

  task automatic model_reset(input bit clr_loss);
    m_s1 = 0; m_s2 = 0; m_state = 0; m_scnt = 0; m_ready = 0;
    if (clr_loss) m_loss = 0;
    for (int c = 0; c < CH; c++) begin
      m_cc[c] = 0; m_div[c] = DD; m_ce[c] = 0; m_sq[c] = 0;
    end
  endtask

  task automatic model(input logic r, input logic pl, input logic wr, input logic [1:0] sel,
                       input logic [DW-1:0] data);
    int lk, nxt;
    bit hold;
    if (r) begin
      model_reset(1'b1);
    end else begin
      lk = m_s2; m_s2 = m_s1; m_s1 = int'(pl);
      hold = (m_state == 2) && (lk != 0);
      nxt = m_state;
      if (m_state == 0) begin
        m_scnt = 0;
        if (lk != 0) nxt = 1;
      end else if (m_state == 1) begin
        if (lk == 0) begin nxt = 0; m_scnt = 0; end
        else if (m_scnt == LD - 1) begin nxt = 2; m_scnt = 0; end
        else m_scnt++;
      end else if (lk == 0) begin
        nxt = 0;
        if (m_loss < 255) m_loss++;
      end
      for (int c = 0; c < CH; c++) begin
        if (wr && int'(sel) == c) begin
          m_div[c] = int'(data); m_cc[c] = 0; m_ce[c] = 0;
          if (!hold) m_sq[c] = 0;
        end else if (hold) begin
          if (m_cc[c] == m_div[c]) begin m_ce[c] = 1; m_cc[c] = 0; m_sq[c] = 1 - m_sq[c]; end
          else begin m_ce[c] = 0; m_cc[c]++; end
        end else begin
          m_cc[c] = 0; m_ce[c] = 0; m_sq[c] = 0;
        end
      end
      m_state = nxt;
      m_ready = (nxt == 2) ? 1 : 0;
    end
  endtask

  task automatic step(input logic r, input logic pl, input logic wr, input logic [1:0] sel,
                      input logic [DW-1:0] data);
    exp_t e;
    @(negedge clock_in);
    reset = r; pll_locked = pl; div_wr = wr; div_sel = sel; div_data = data;
    model(r, pl, wr, sel, data);
    e.outs = {m_ready[0], ~m_ready[0], m_ce[1][0], m_ce[0][0], m_sq[1][0], m_sq[0][0]};
    e.loss = m_loss;
    q.push_back(e);
    @(posedge clock_in);
    #2;
  endtask

  always @(posedge clock_in) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("cycle_outputs", int'({ready, rst_out, ce[1], ce[0], sq[1], sq[0]}), int'(mon_e.outs));
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      check("cycle_loss_count", int'(loss_count), mon_e.loss);
`endif
    end
  end

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, '0);
    step(1'b1, 1'b0, 1'b0, 2'd0, '0);
  endtask

  // Holds lock high until ready rises; returns the edge count, or -1 on timeout
  task automatic lock_up(output int gap);
    gap = -1;
    for (int k = 1; k <= 100 && gap < 0; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, '0);
      if (ready) gap = k;
    end
  endtask

  task automatic measure(output int p0, output int p1);
    int last0, prev0, last1, prev1;
    last0 = -1; prev0 = -1; last1 = -1; prev1 = -1;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, '0);
      if (ce[0]) begin prev0 = last0; last0 = k; end
      if (ce[1]) begin prev1 = last1; last1 = k; end
    end
    p0 = (prev0 >= 0) ? last0 - prev0 : -1;
    p1 = (prev1 >= 0) ? last1 - prev1 : -1;
  endtask

  typedef struct {
    string name;
    int    glitch_at;
    int    wr_sel;
    int    wr_data;
    int    exp_gap;
    int    exp_p0;
    int    exp_p1;
  } scen_t;
  scen_t tbl[5];

  initial begin
    int gap, p0, p1, prev_sq1;
    model_reset(1'b1);
    tbl[0] = '{"plain",        -1, -1, 0, 19, 4, 4};
    tbl[1] = '{"glitch",       10, -1, 0, 19, 4, 4};
    tbl[2] = '{"ch1_div0",     -1,  1, 0, 19, 4, 1};
    tbl[3] = '{"bad_sel",      -1,  3, 0, 19, 4, 4};
    tbl[4] = '{"ch0_div6",     -1,  0, 6, 19, 7, 4};

    do_reset();
    check("reset_ready", int'(ready), 0);
    check("reset_rst_out", int'(rst_out), 1);
    check("reset_ce", int'(ce), 0);
    check("reset_sq", int'(sq), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      if (tbl[i].glitch_at >= 0) begin
        repeat (tbl[i].glitch_at + 3) step(1'b0, 1'b1, 1'b0, 2'd0, '0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, '0);
      end
      lock_up(gap);
      check({tbl[i].name, "_ready_gap"}, gap, tbl[i].exp_gap);
      if (tbl[i].wr_sel >= 0) step(1'b0, 1'b1, 1'b1, 2'(tbl[i].wr_sel), DW'(tbl[i].wr_data));
      measure(p0, p1);
      check({tbl[i].name, "_period0"}, p0, tbl[i].exp_p0);
      check({tbl[i].name, "_period1"}, p1, tbl[i].exp_p1);
    end

    // Divider write in RUN, then lock loss and relock with dividers retained
    do_reset();
    lock_up(gap);
    repeat (2) step(1'b0, 1'b1, 1'b0, 2'd0, '0);
    step(1'b0, 1'b1, 1'b1, 2'd1, 8'd0);
    check("wr_cycle_ce1", int'(ce[1]), 0);
    step(1'b0, 1'b1, 1'b0, 2'd0, '0);
    check("after_wr_ce1", int'(ce[1]), 1);
    prev_sq1 = int'(sq[1]);
    step(1'b0, 1'b1, 1'b0, 2'd0, '0);
    check("sq1_toggle", int'(sq[1]), 1 - prev_sq1);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0);
    check("loss_ready_still", int'(ready), 1);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0);
    check("loss_ready", int'(ready), 0);
    check("loss_rst_out", int'(rst_out), 1);
    check("loss_ce", int'(ce), 0);
    check("loss_sq", int'(sq), 0);
    lock_up(gap);
    check("relock_gap", gap, 19);
    measure(p0, p1);
    check("relock_period0", p0, 4);
    check("relock_period1", p1, 1);

    // Reset wins over a same-cycle divider write
    step(1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0);
    lock_up(gap);
    measure(p0, p1);
    check("rst_over_wr_period0", p0, 4);

`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
    do_reset();
    for (int n = 0; n < 3; n++) begin
      lock_up(gap);
      repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, '0);
    end
    check("loss_count_3", int'(loss_count), 3);
    step(1'b1, 1'b0, 1'b0, 2'd0, '0);
    check("loss_count_reset", int'(loss_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
